// File: rtl/alu_sweep_pkg.sv
// Shared types and constants for the ALU opcode-sweep initiator.
//   state_e : sweep FSM states
//   DATA_W  : ALU operand/result width
//   CTRL_W  : ALU opcode width
//   OP_LAST : final opcode of a sweep
//   SIG_W   : width of the optional result signature
package alu_sweep_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CTRL_W = 4;
  localparam int unsigned SIG_W  = 16;

  localparam logic [CTRL_W-1:0] OP_LAST = 4'hF;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StHold
  } state_e;

endpackage

// File: rtl/alu_sweep_sig.sv
// Result signature register for the ALU sweep initiator.
// Rotate-left-by-one and XOR in {carry, data} for every accepted result.
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_clear        : clear the signature (accepted start)
//   i_update       : fold the current result into the signature
//   i_data         : result data being accepted
//   i_carry        : result carry being accepted
//   o_sig          : current signature
module alu_sweep_sig
  import alu_sweep_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_update,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_carry,
  output logic [SIG_W-1:0]  o_sig
);

  logic [SIG_W-1:0] r_sig;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sig <= '0;
    end else if (i_clear) begin
      r_sig <= '0;
    end else if (i_update) begin
      r_sig <= {r_sig[SIG_W-2:0], r_sig[SIG_W-1]} ^ {7'b0, i_carry, i_data};
    end
  end

  assign o_sig = r_sig;

endmodule

// File: rtl/alu_sweep_driver.sv
// ALU opcode-sweep initiator. Latches an operand pair on start, drives all 16
// opcodes in ascending order, samples the ALU after SETTLE_CYCLES and returns
// each result over a valid/ready stream.
// Optional feature: define ALU_SWEEP_SIGNATURE_EN to add the o_sig output.
// Ports:
//   i_clk, i_rst_n         : clock, synchronous active-low reset
//   i_start, i_abort       : launch a sweep / cancel an active sweep
//   i_a_in, i_b_in         : operands, latched on accepted start
//   i_alu_out, i_alu_carry : ALU result
//   o_alu_a/b/ctrl         : registered ALU inputs
//   o_res_valid/i_res_ready: result stream handshake
//   o_res_op/data/carry    : result payload
//   o_busy, o_done         : sweep in progress / final result accepted pulse
//   o_sig                  : result signature (ALU_SWEEP_SIGNATURE_EN only)
module alu_sweep_driver
  import alu_sweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [DATA_W-1:0] i_a_in,
  input  logic [DATA_W-1:0] i_b_in,
  input  logic [DATA_W-1:0] i_alu_out,
  input  logic              i_alu_carry,
  output logic [DATA_W-1:0] o_alu_a,
  output logic [DATA_W-1:0] o_alu_b,
  output logic [CTRL_W-1:0] o_alu_ctrl,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic [CTRL_W-1:0] o_res_op,
  output logic [DATA_W-1:0] o_res_data,
  output logic              o_res_carry,
  output logic              o_busy,
  output logic              o_done
`ifdef ALU_SWEEP_SIGNATURE_EN
  ,
  output logic [SIG_W-1:0]  o_sig
`endif
);

  localparam int unsigned CntW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(SETTLE_CYCLES - 1);

  if (SETTLE_CYCLES == 0) begin : g_bad_settle
    $error("SETTLE_CYCLES must be at least 1");
  end

  state_e            r_state;
  logic [CntW-1:0]   r_cnt;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [CTRL_W-1:0] r_alu_ctrl;
  logic              r_res_valid;
  logic [CTRL_W-1:0] r_res_op;
  logic [DATA_W-1:0] r_res_data;
  logic              r_res_carry;
  logic              r_busy;
  logic              r_done;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_ctrl  <= '0;
      r_res_valid <= 1'b0;
      r_res_op    <= '0;
      r_res_data  <= '0;
      r_res_carry <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          // start wins over a simultaneous abort; abort alone is a no-op here
          if (i_start) begin
            r_alu_a    <= i_a_in;
            r_alu_b    <= i_b_in;
            r_alu_ctrl <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            r_state    <= StSettle;
          end
        end
        StSettle: begin
          if (i_abort) begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end else if (r_cnt == CntLast) begin
            r_res_data  <= i_alu_out;
            r_res_carry <= i_alu_carry;
            r_res_op    <= r_alu_ctrl;
            r_res_valid <= 1'b1;
            r_state     <= StHold;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StHold: begin
          // abort beats a same-cycle handshake: the pending result is dropped
          if (i_abort) begin
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= StIdle;
          end else if (i_res_ready) begin
            r_res_valid <= 1'b0;
            if (r_alu_ctrl == OP_LAST) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= StIdle;
            end else begin
              r_alu_ctrl <= r_alu_ctrl + 1'b1;
              r_cnt      <= '0;
              r_state    <= StSettle;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_alu_a     = r_alu_a;
  assign o_alu_b     = r_alu_b;
  assign o_alu_ctrl  = r_alu_ctrl;
  assign o_res_valid = r_res_valid;
  assign o_res_op    = r_res_op;
  assign o_res_data  = r_res_data;
  assign o_res_carry = r_res_carry;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

`ifdef ALU_SWEEP_SIGNATURE_EN
  logic w_sig_clear;
  logic w_sig_update;

  assign w_sig_clear  = (r_state == StIdle) && i_start;
  assign w_sig_update = (r_state == StHold) && i_res_ready && !i_abort;

  alu_sweep_sig u_sig (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (w_sig_clear),
    .i_update (w_sig_update),
    .i_data   (r_res_data),
    .i_carry  (r_res_carry),
    .o_sig    (o_sig)
  );
`endif

endmodule

// File: tb/tb_alu_sweep_driver.sv
// Directed bench for alu_sweep_driver: one instance with SETTLE_CYCLES=1 and
// one with SETTLE_CYCLES=3, each driving a model ALU (out = a ^ ctrl,
// carry = ctrl[0]).
module tb_alu_sweep_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // SETTLE_CYCLES = 1 instance
  logic       start, abort, res_ready;
  logic [7:0] a_in, b_in;
  logic [7:0] alu_out, alu_a, alu_b, res_data;
  logic       alu_carry, res_valid, res_carry, busy, done;
  logic [3:0] alu_ctrl, res_op;

  // SETTLE_CYCLES = 3 instance
  logic       s3_start, s3_abort, s3_ready;
  logic [7:0] s3_a_in, s3_b_in;
  logic [7:0] s3_alu_out, s3_alu_a, s3_alu_b, s3_res_data;
  logic       s3_alu_carry, s3_res_valid, s3_res_carry, s3_busy, s3_done;
  logic [3:0] s3_alu_ctrl, s3_res_op;

`ifdef ALU_SWEEP_SIGNATURE_EN
  logic [15:0] sig, s3_sig;
  logic [15:0] exp_sig;
`endif

  assign alu_out      = alu_a ^ {4'b0, alu_ctrl};
  assign alu_carry    = alu_ctrl[0];
  assign s3_alu_out   = s3_alu_a ^ {4'b0, s3_alu_ctrl};
  assign s3_alu_carry = s3_alu_ctrl[0];

  alu_sweep_driver #(.SETTLE_CYCLES(1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_a_in(a_in), .i_b_in(b_in), .i_alu_out(alu_out), .i_alu_carry(alu_carry),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_ctrl(alu_ctrl),
    .o_res_valid(res_valid), .i_res_ready(res_ready), .o_res_op(res_op),
    .o_res_data(res_data), .o_res_carry(res_carry), .o_busy(busy), .o_done(done)
`ifdef ALU_SWEEP_SIGNATURE_EN
    , .o_sig(sig)
`endif
  );

  alu_sweep_driver #(.SETTLE_CYCLES(3)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(s3_start), .i_abort(s3_abort),
    .i_a_in(s3_a_in), .i_b_in(s3_b_in), .i_alu_out(s3_alu_out),
    .i_alu_carry(s3_alu_carry), .o_alu_a(s3_alu_a), .o_alu_b(s3_alu_b),
    .o_alu_ctrl(s3_alu_ctrl), .o_res_valid(s3_res_valid), .i_res_ready(s3_ready),
    .o_res_op(s3_res_op), .o_res_data(s3_res_data), .o_res_carry(s3_res_carry),
    .o_busy(s3_busy), .o_done(s3_done)
`ifdef ALU_SWEEP_SIGNATURE_EN
    , .o_sig(s3_sig)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; abort = 1'b0; res_ready = 1'b1; a_in = 8'h00; b_in = 8'h00;
    s3_start = 1'b0; s3_abort = 1'b0; s3_ready = 1'b1; s3_a_in = 8'h00; s3_b_in = 8'h00;
    tick();
    tick();

    // Reset state
    check("rst_valid", res_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_alu_a", alu_a, 8'h00);
    check("rst_alu_ctrl", alu_ctrl, 4'h0);
    check("rst_res_data", res_data, 8'h00);
    rst_n = 1'b1;
    tick();

    // Free-running sweep with start/a_in wiggled while busy
    a_in = 8'hFF; b_in = 8'hFF; start = 1'b1;
    tick();  // E0
    check("launch_busy", busy, 1'b1);
    check("launch_alu_a", alu_a, 8'hFF);
    check("launch_alu_b", alu_b, 8'hFF);
    check("launch_ctrl", alu_ctrl, 4'h0);
`ifdef ALU_SWEEP_SIGNATURE_EN
    check("sig_cleared", sig, 16'h0000);
    exp_sig = 16'h0000;
`endif
    a_in = 8'h55;  // start still high: must be ignored while busy
    for (int k = 1; k <= 32; k++) begin
      if (k == 5) start = 1'b0;
      tick();
      if (k % 2 == 1) begin
        logic [3:0] op;
        op = 4'((k - 1) / 2);
        check("sweep_valid", res_valid, 1'b1);
        check("sweep_op", res_op, op);
        check("sweep_data", res_data, 8'hFF ^ {4'h0, op});
        check("sweep_carry", res_carry, op[0]);
`ifdef ALU_SWEEP_SIGNATURE_EN
        exp_sig = {exp_sig[14:0], exp_sig[15]} ^ {7'b0, op[0], 8'hFF ^ {4'h0, op}};
`endif
      end else begin
        check("sweep_gap", res_valid, 1'b0);
      end
      check("sweep_alu_a", alu_a, 8'hFF);
      check("sweep_done", done, (k == 32) ? 1'b1 : 1'b0);
    end
    check("sweep_end_busy", busy, 1'b0);
`ifdef ALU_SWEEP_SIGNATURE_EN
    check("sig_final", sig, exp_sig);
`endif
    tick();
    check("done_pulse_len", done, 1'b0);

    // Backpressure at op 3
    a_in = 8'hFF; start = 1'b1;
    tick();  // E0
    start = 1'b0;
    for (int k = 1; k <= 6; k++) tick();
    res_ready = 1'b0;
    tick();  // k=7: op 3 valid
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", res_valid, 1'b1);
      check("bp_data", res_data, 8'hFC);
      check("bp_op", res_op, 4'h3);
      check("bp_ctrl", alu_ctrl, 4'h3);
      if (c < 4) tick();
    end
    res_ready = 1'b1;
    tick();  // handshake edge
    check("bp_release_valid", res_valid, 1'b0);
    check("bp_release_ctrl", alu_ctrl, 4'h4);
    tick();
    check("bp_op4_valid", res_valid, 1'b1);
    check("bp_op4_op", res_op, 4'h4);
    check("bp_op4_data", res_data, 8'hFB);

    // Abort at op 7 together with a handshake
    for (int k = 0; k < 6; k++) tick();
    check("ab_pre_op", res_op, 4'h7);
    check("ab_pre_valid", res_valid, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_busy", busy, 1'b0);
    check("ab_valid", res_valid, 1'b0);
    check("ab_done", done, 1'b0);
    check("ab_ctrl_kept", alu_ctrl, 4'h7);
    check("ab_alu_a_kept", alu_a, 8'hFF);
    abort = 1'b1;  // abort in IDLE is a no-op
    tick();
    abort = 1'b0;
    check("ab_idle_done", done, 1'b0);
    check("ab_idle_busy", busy, 1'b0);

    // Relaunch with a_in = 0
    a_in = 8'h00; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("relaunch_valid", res_valid, 1'b1);
    check("relaunch_op", res_op, 4'h0);
    check("relaunch_data", res_data, 8'h00);

    // Reset during SETTLE of op 9 (op 8 valid at k=17, op 9 settling at k=18)
    for (int k = 2; k <= 18; k++) tick();
    check("mid_ctrl", alu_ctrl, 4'h9);
    check("mid_valid", res_valid, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mrst_alu_a", alu_a, 8'h00);
    check("mrst_alu_b", alu_b, 8'h00);
    check("mrst_ctrl", alu_ctrl, 4'h0);
    check("mrst_valid", res_valid, 1'b0);
    check("mrst_op", res_op, 4'h0);
    check("mrst_data", res_data, 8'h00);
    check("mrst_busy", busy, 1'b0);
    check("mrst_done", done, 1'b0);
    tick();
    check("mrst_idle", busy, 1'b0);

    // Slow settle, SETTLE_CYCLES = 3
    s3_a_in = 8'h3C; s3_b_in = 8'hC3; s3_start = 1'b1;
    tick();  // E0
    s3_start = 1'b0;
    check("s3_launch_busy", s3_busy, 1'b1);
    for (int k = 1; k <= 64; k++) begin
      tick();
      if (k % 4 == 3) begin
        logic [3:0] op;
        op = 4'((k - 3) / 4);
        check("s3_valid", s3_res_valid, 1'b1);
        check("s3_op", s3_res_op, op);
        check("s3_data", s3_res_data, 8'h3C ^ {4'h0, op});
      end else begin
        check("s3_gap", s3_res_valid, 1'b0);
      end
      check("s3_done", s3_done, (k == 64) ? 1'b1 : 1'b0);
    end
    check("s3_end_busy", s3_busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sweep_driver.md
# alu_sweep_driver

Synthesizable initiator for the 8-bit ALU. It latches an operand pair, drives all 16 `ctrl` opcodes in ascending order, and samples `out`/`carry` after a programmable settle time. It returns each result over a valid/ready stream. It sits between a host/self-test controller and the combinational `ALU`, and acts as the hardware counterpart of the opcode-sweep stimulus.

## Interface
- `SETTLE_CYCLES`, 1: cycles between driving an opcode and sampling the ALU; must be ≥1 (elaboration-time check).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: begin a sweep; sampled only in IDLE.
- `abort` in 1: cancel an active sweep.
- `a_in` in 8: operand A, latched on accepted `start`.
- `b_in` in 8: operand B, latched on accepted `start`.
- `alu_out` in 8: ALU result.
- `alu_carry` in 1: ALU carry.
- `alu_a` out 8: registered operand A to the ALU.
- `alu_b` out 8: registered operand B to the ALU.
- `alu_ctrl` out 4: registered opcode to the ALU.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts the result.
- `res_op` out 4: opcode that produced `res_data`.
- `res_data` out 8: captured `alu_out`.
- `res_carry` out 1: captured `alu_carry`.
- `busy` out 1: sweep in progress.
- `done` out 1: one-cycle pulse when the 16th result is accepted.

## Operation
- **States**: IDLE, SETTLE, HOLD.
- **IDLE → SETTLE**: on `start`=1.
  - Latch `alu_a`←`a_in`, `alu_b`←`b_in`, `alu_ctrl`←0.
  - Clear the settle counter; `busy`←1.
- **SETTLE**: counter increments each edge. On the edge where the counter equals `SETTLE_CYCLES`-1:
  - `res_data`←`alu_out`, `res_carry`←`alu_carry`, `res_op`←`alu_ctrl`.
  - `res_valid`←1; go to HOLD.
- **HOLD, no handshake**: while `res_valid`=1 and `res_ready`=0, all outputs are held stable.
- **HOLD, handshake and `alu_ctrl`≠15**:
  - `alu_ctrl`←`alu_ctrl`+1, `res_valid`←0.
  - Clear the counter; go to SETTLE.
- **HOLD, handshake and `alu_ctrl`=15**:
  - `res_valid`←0, `busy`←0, `done`←1 for one cycle; go to IDLE.
  - `alu_ctrl` never wraps to 0 within a sweep.
- **`start` while busy**: ignored.
- **`a_in`/`b_in` after launch**: changes have no effect until the next accepted `start`.
- **`abort`**: in SETTLE or HOLD, the next edge gives IDLE, `res_valid`←0, `busy`←0, no `done`.
  - `alu_a`, `alu_b`, `alu_ctrl` retain their values.
  - `abort` has priority over a simultaneous handshake.
  - `abort` in IDLE has no effect.
- **`start` and `abort` both high in IDLE**: `start` wins.
- **Reset values**: all outputs 0, state IDLE. This applies identically mid-sweep; any pending result is discarded.

## Timing
- All outputs are registered.
- **Launch**: with `start` sampled at edge E0, ALU inputs are valid after E0.
- **First result**: `res_valid` rises at edge E0+`SETTLE_CYCLES`.
- **Per-op period**: with `res_ready` held 1, `SETTLE_CYCLES`+1 cycles, and each `res_valid` lasts exactly one cycle.
- **Full sweep**: 16×(`SETTLE_CYCLES`+1) cycles from E0 to the `done` edge.
- **Back-to-back**: `start` may be accepted on the cycle after `done`.
- **Settle counter**: width is `$clog2(SETTLE_CYCLES+1)`.

## Configuration
- **`ALU_SWEEP_SIGNATURE_EN` defined**: adds output `sig` (16 bits, reset 0).
  - Cleared on accepted `start`.
  - On each accepted result: `sig`←{`sig`[14:0],`sig`[15]} ^ {7'b0,`res_carry`,`res_data`}.
  - Holds after `done` until the next `start`.
- **Not defined**: the port and its logic are absent.

## Structure
- **Package `alu_sweep_pkg`**:
  - state enum (IDLE/SETTLE/HOLD);
  - `DATA_W`=8, `CTRL_W`=4, `OP_LAST`=4'hF, `SIG_W`=16.
- **Sub-module `alu_sweep_sig`**: the signature register, instantiated only under `ALU_SWEEP_SIGNATURE_EN`.
- **Bench ALU model**: `out`=`a`^{4'b0,`ctrl`}, `carry`=`ctrl`[0].

## Test plan
- **Free-running sweep**: `a_in`=`b_in`=8'hFF, `SETTLE_CYCLES`=1, `res_ready`=1, `start` pulse → 16 one-cycle results.
  - `res_op` runs 0..15 with `res_data`=8'hFF^op.
  - Results arrive 2 cycles apart; `done` at start+32.
- **Backpressure**: `res_ready`=0 for 5 cycles when `res_op`=3 → `res_valid`, `res_data`=8'hFC and `alu_ctrl`=3 are stable for all 5 cycles; op 4 follows the release.
- **Abort**: `abort` at `res_op`=7 with a simultaneous handshake → IDLE next edge, `busy`=0, no `done`. A new `start` with `a_in`=8'h00 yields `res_op`=0, `res_data`=8'h00.
- **Reset mid-sweep**: `rst_n`=0 for 1 cycle during SETTLE of op 9 → all outputs 0, IDLE.
- **Ignored inputs while busy**: `start` and `a_in`=8'h55 driven while busy → sweep unaffected, `alu_a` stays 8'hFF.
- **Slow settle**: `SETTLE_CYCLES`=3, `res_ready`=1 → period 4 cycles, `done` at start+64.
- **Signature**: with `ALU_SWEEP_SIGNATURE_EN` defined, `sig` after `done` matches the bench model's computed value.
